// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris game controller: state codes, default
// gravity constants and a row popcount helper.
package tetris_pkg;

    localparam logic [2:0] GEN_CODE      = 3'd0;
    localparam logic [2:0] MOVE_CODE     = 3'd1;
    localparam logic [2:0] LAND_CODE     = 3'd2;
    localparam logic [2:0] CLEAR_CODE    = 3'd3;
    localparam logic [2:0] NEWBOARD_CODE = 3'd4;
    localparam logic [2:0] GAMEOVER_CODE = 3'd5;
    localparam logic [2:0] PAUSE_CODE    = 3'd6;

    typedef enum logic [2:0] {
        ST_GEN      = GEN_CODE,
        ST_MOVE     = MOVE_CODE,
        ST_LAND     = LAND_CODE,
        ST_CLEAR    = CLEAR_CODE,
        ST_NEWBOARD = NEWBOARD_CODE,
        ST_GAMEOVER = GAMEOVER_CODE,
        ST_PAUSE    = PAUSE_CODE
    } state_t;

    localparam logic [23:0] DROP_INIT_DEF = 24'd5_000_000;
    localparam logic [23:0] DROP_STEP_DEF = 24'd400_000;
    localparam logic [23:0] DROP_MIN_DEF  = 24'd500_000;

    // Boards up to MAX_ROWS rows are supported by the popcount helper.
    localparam int MAX_ROWS = 32;
    localparam int POP_W    = 6;

    // Number of set row flags.
    function automatic logic [POP_W-1:0] popcount(input logic [MAX_ROWS-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_ROWS; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/drop_timer.sv
// Gravity timer: counts enabled cycles and emits a tick on the last cycle of
// each period. Holds its count while disabled; clear has priority.
module drop_timer #(
    parameter int TIMER_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               clear,
    input  logic [TIMER_W-1:0] period,
    output logic               tick
);

    logic [TIMER_W-1:0] count;
    logic               at_end;

    // ">=" keeps the counter safe if the period ever shrinks below the count.
    assign at_end = (count >= period - TIMER_W'(1));
    assign tick   = enable && at_end;

    // Count enabled cycles, wrapping to zero after the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= at_end ? '0 : count + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/game_ctrl_fsm.sv
// Main Tetris game controller: sequences generate/move/land/clear phases,
// handles pause, counts cleared lines and drives level-based gravity speed.
module game_ctrl_fsm
    import tetris_pkg::*;
#(
    parameter int                 ROWS            = 20,
    parameter int                 TIMER_W         = 24,
    parameter logic [TIMER_W-1:0] DROP_INIT       = DROP_INIT_DEF,
    parameter logic [TIMER_W-1:0] DROP_STEP       = DROP_STEP_DEF,
    parameter logic [TIMER_W-1:0] DROP_MIN        = DROP_MIN_DEF,
    parameter int                 LINES_PER_LEVEL = 10,
    parameter int                 LINE_W          = 16,
    parameter int                 LEVEL_W         = 5
) (
    input  logic                clka,
    input  logic                rst_n,
    input  logic                restart,
    input  logic                start,
    input  logic                pause,
    input  logic                gen_done,
    input  logic                spawn_blocked,
    input  logic                touched,
    input  logic                land_done,
    input  logic                land_error,
    input  logic [ROWS-1:0]     full_rows,
    input  logic                clear_done,
    output logic [2:0]          state,
    output logic                start_gen,
    output logic                start_move,
    output logic                start_land,
    output logic                start_clear,
    output logic                drop_tick,
    output logic [ROWS-1:0]     clear_mask,
    output logic [LINE_W-1:0]   lines,
    output logic [LEVEL_W-1:0]  level
);

    localparam int SUB_W  = LINE_W;
    localparam int PROD_W = TIMER_W + LEVEL_W;
    localparam logic [PROD_W-1:0] SPAN = PROD_W'(DROP_INIT - DROP_MIN);

    state_t             state_q;
    state_t             next_state;
    logic [SUB_W-1:0]   sub_cnt;
    logic [POP_W-1:0]   pop;
    logic [LINE_W:0]    lines_sum;
    logic [SUB_W:0]     sub_sum;
    logic [SUB_W-1:0]   sub_sat;
    logic [SUB_W-1:0]   sub_next;
    logic               level_up;
    logic [PROD_W-1:0]  step_total;
    logic [TIMER_W-1:0] period;
    logic               timer_clear;

    assign state = state_q;

    // Line and level bookkeeping for the clear currently in progress.
    assign pop       = popcount(MAX_ROWS'(clear_mask));
    assign lines_sum = {1'b0, lines} + (LINE_W+1)'(pop);
    assign sub_sum   = {1'b0, sub_cnt} + (SUB_W+1)'(pop);
    assign sub_sat   = sub_sum[SUB_W] ? '1 : sub_sum[SUB_W-1:0];
    assign level_up  = (sub_sat >= SUB_W'(LINES_PER_LEVEL));
    assign sub_next  = level_up ? sub_sat - SUB_W'(LINES_PER_LEVEL) : sub_sat;

    // Gravity period, compared in a wide domain so the subtraction never wraps.
    assign step_total = PROD_W'(level) * PROD_W'(DROP_STEP);
    assign period     = (step_total >= SPAN) ? DROP_MIN
                                             : DROP_INIT - step_total[TIMER_W-1:0];

    // Timer runs in MOVE, freezes in PAUSE and is zeroed everywhere else.
    assign timer_clear = restart || ((state_q != ST_MOVE) && (state_q != ST_PAUSE));

    drop_timer #(
        .TIMER_W (TIMER_W)
    ) u_drop_timer (
        .clk    (clka),
        .rst_n  (rst_n),
        .enable (state_q == ST_MOVE),
        .clear  (timer_clear),
        .period (period),
        .tick   (drop_tick)
    );

    // Next-state selection; restart overrides everything.
    always_comb begin
        next_state = state_q;
        if (restart) begin
            next_state = ST_NEWBOARD;
        end else begin
            case (state_q)
                ST_NEWBOARD: if (start) next_state = ST_GEN;
                ST_GEN:      if (gen_done) next_state = spawn_blocked ? ST_GAMEOVER : ST_MOVE;
                ST_MOVE: begin
                    if (touched)    next_state = ST_LAND;
                    else if (pause) next_state = ST_PAUSE;
                end
                ST_PAUSE:    if (!pause) next_state = ST_MOVE;
                ST_LAND: begin
                    if (land_done) begin
                        if (land_error)      next_state = ST_GAMEOVER;
                        else if (|full_rows) next_state = ST_CLEAR;
                        else                 next_state = ST_GEN;
                    end
                end
                ST_CLEAR:    if (clear_done) next_state = ST_GEN;
                ST_GAMEOVER: next_state = ST_GAMEOVER;
                default:     next_state = ST_NEWBOARD;
            endcase
        end
    end

    // State register plus registered phase pulses, mask and counters.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_NEWBOARD;
            start_gen   <= 1'b0;
            start_move  <= 1'b0;
            start_land  <= 1'b0;
            start_clear <= 1'b0;
            clear_mask  <= '0;
            lines       <= '0;
            level       <= '0;
            sub_cnt     <= '0;
        end else begin
            state_q     <= next_state;
            start_gen   <= (next_state == ST_GEN)   && (state_q != ST_GEN);
            start_move  <= (next_state == ST_MOVE);
            start_land  <= (next_state == ST_LAND)  && (state_q != ST_LAND);
            start_clear <= (next_state == ST_CLEAR) && (state_q != ST_CLEAR);
            if (restart || ((state_q == ST_NEWBOARD) && start)) begin
                clear_mask <= '0;
                lines      <= '0;
                level      <= '0;
                sub_cnt    <= '0;
            end else begin
                if ((state_q == ST_LAND) && land_done && !land_error && (|full_rows)) begin
                    clear_mask <= full_rows;
                end
                if ((state_q == ST_CLEAR) && clear_done) begin
                    clear_mask <= '0;
                    lines      <= lines_sum[LINE_W] ? '1 : lines_sum[LINE_W-1:0];
                    sub_cnt    <= sub_next;
                    if (level_up && (level != '1)) begin
                        level <= level + LEVEL_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Self-checking bench for game_ctrl_fsm with a fast gravity configuration
// (period 10 at level 0, minus 2 per level, floor 4).
module tb_game_ctrl_fsm;

    localparam int EXP_W = 49;

    localparam logic [8:0] C_RESTART = 9'h100;
    localparam logic [8:0] C_START   = 9'h080;
    localparam logic [8:0] C_PAUSE   = 9'h040;
    localparam logic [8:0] C_GEN     = 9'h020;
    localparam logic [8:0] C_SPAWN   = 9'h010;
    localparam logic [8:0] C_TOUCH   = 9'h008;
    localparam logic [8:0] C_LDONE   = 9'h004;
    localparam logic [8:0] C_LERR    = 9'h002;
    localparam logic [8:0] C_CDONE   = 9'h001;

    localparam logic [2:0] S_GEN = 3'd0, S_MOVE = 3'd1, S_LAND = 3'd2, S_CLEAR = 3'd3;
    localparam logic [2:0] S_NB  = 3'd4, S_OVER = 3'd5, S_PAUSE = 3'd6;

    typedef struct packed {
        logic [8:0]  ctl;
        logic [19:0] rows;
        logic [2:0]  st;
        logic [19:0] mask;
        logic [15:0] lines;
        logic [4:0]  level;
    } step_t;

    logic        clka, rst_n;
    logic        restart, start, pause, gen_done, spawn_blocked, touched;
    logic        land_done, land_error, clear_done;
    logic [19:0] full_rows;
    logic [2:0]  state;
    logic        start_gen, start_move, start_land, start_clear, drop_tick;
    logic [19:0] clear_mask;
    logic [15:0] lines;
    logic [4:0]  level;

    logic [EXP_W-1:0] exp_q[$];
    step_t            seq_q[$];
    logic [2:0]       m_prev;
    int               tcount;
    int               n_cmp;
    int               n_fail;

    game_ctrl_fsm #(
        .ROWS            (20),
        .TIMER_W         (24),
        .DROP_INIT       (24'd10),
        .DROP_STEP       (24'd2),
        .DROP_MIN        (24'd4),
        .LINES_PER_LEVEL (10),
        .LINE_W          (16),
        .LEVEL_W         (5)
    ) dut (
        .clka          (clka),
        .rst_n         (rst_n),
        .restart       (restart),
        .start         (start),
        .pause         (pause),
        .gen_done      (gen_done),
        .spawn_blocked (spawn_blocked),
        .touched       (touched),
        .land_done     (land_done),
        .land_error    (land_error),
        .full_rows     (full_rows),
        .clear_done    (clear_done),
        .state         (state),
        .start_gen     (start_gen),
        .start_move    (start_move),
        .start_land    (start_land),
        .start_clear   (start_clear),
        .drop_tick     (drop_tick),
        .clear_mask    (clear_mask),
        .lines         (lines),
        .level         (level)
    );

    // Clock and watchdog.
    initial clka = 1'b0;
    always #5 clka = ~clka;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [EXP_W-1:0] snap();
        return {state, start_gen, start_move, start_land, start_clear, drop_tick,
                clear_mask, lines, level};
    endfunction

    function automatic logic [EXP_W-1:0] pack(logic [2:0] st, logic sg, logic sm, logic sl,
                                              logic sc, logic dt, logic [19:0] m,
                                              logic [15:0] l, logic [4:0] v);
        return {st, sg, sm, sl, sc, dt, m, l, v};
    endfunction

    function automatic int per_of(int lvl);
        int p;
        p = 10 - 2 * lvl;
        return (p < 4) ? 4 : p;
    endfunction

    function automatic void add(logic [8:0] ctl, logic [19:0] rows, logic [2:0] st,
                                logic [19:0] mask, logic [15:0] l, logic [4:0] v);
        step_t s;
        s.ctl = ctl; s.rows = rows; s.st = st; s.mask = mask; s.lines = l; s.level = v;
        seq_q.push_back(s);
    endfunction

    // Driver: applies one cycle of inputs and pushes the outputs expected
    // after the next edge, using a gravity model of the cycles spent in MOVE.
    task automatic apply(input step_t s);
        int per;
        logic tick;
        {restart, start, pause, gen_done, spawn_blocked, touched,
         land_done, land_error, clear_done} = s.ctl;
        full_rows = s.rows;
        per = per_of(int'(s.level));
        if (m_prev != S_MOVE && m_prev != S_PAUSE) tcount = 0;
        else if (m_prev == S_MOVE) tcount = (tcount >= per - 1) ? 0 : tcount + 1;
        tick = (s.st == S_MOVE) && (tcount == per - 1);
        exp_q.push_back(pack(s.st,
                             (s.st == S_GEN)   && (m_prev != S_GEN),
                             (s.st == S_MOVE),
                             (s.st == S_LAND)  && (m_prev != S_LAND),
                             (s.st == S_CLEAR) && (m_prev != S_CLEAR),
                             tick, s.mask, s.lines, s.level));
        m_prev = s.st;
    endtask

    task automatic idle_inputs();
        {restart, start, pause, gen_done, spawn_blocked, touched,
         land_done, land_error, clear_done} = '0;
        full_rows = '0;
    endtask

    task automatic test_reset();
        logic [EXP_W-1:0] got, exp;
        step_t s;
        int k;
        rst_n = 1'b0;
        idle_inputs();
        m_prev = S_NB;
        tcount = 0;
        repeat (2) @(posedge clka);
        #1;
        exp_q.push_back(pack(S_NB, 0, 0, 0, 0, 0, '0, '0, '0));
        got = snap(); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_hold: got %h expected %h", got, exp);
        end
        rst_n = 1'b1;
        add(9'h0, '0, S_NB, '0, 0, 0);
        add(C_PAUSE | C_GEN | C_LDONE | C_CDONE, 20'h1, S_NB, '0, 0, 0);
        k = 0;
        while (seq_q.size() > 0) begin
            s = seq_q.pop_front(); apply(s); @(posedge clka); #1;
            got = snap(); exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_release step %0d: got %h expected %h", k, got, exp);
            end
            k++;
        end
    endtask

    task automatic test_start_move();
        logic [EXP_W-1:0] got, exp;
        step_t s;
        int k;
        add(C_START, '0, S_GEN, '0, 0, 0);
        add(C_LDONE | C_CDONE | C_TOUCH, 20'h3, S_GEN, '0, 0, 0);
        add(9'h0, '0, S_GEN, '0, 0, 0);
        add(C_GEN, '0, S_MOVE, '0, 0, 0);
        k = 0;
        while (seq_q.size() > 0) begin
            s = seq_q.pop_front(); apply(s); @(posedge clka); #1;
            got = snap(); exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL start_move step %0d: got %h expected %h", k, got, exp);
            end
            k++;
        end
    endtask

    task automatic test_gravity_pause();
        logic [EXP_W-1:0] got, exp;
        step_t s;
        int k;
        for (int i = 0; i < 26; i++) add(9'h0, '0, S_MOVE, '0, 0, 0);
        add(C_PAUSE, '0, S_PAUSE, '0, 0, 0);
        for (int i = 0; i < 19; i++)
            add(C_PAUSE | ((i % 4 == 0) ? C_TOUCH : 9'h0), '0, S_PAUSE, '0, 0, 0);
        for (int i = 0; i < 13; i++) add(9'h0, '0, S_MOVE, '0, 0, 0);
        // touched and pause together, in the tick cycle: touched wins
        add(C_TOUCH | C_PAUSE, '0, S_LAND, '0, 0, 0);
        k = 0;
        while (seq_q.size() > 0) begin
            s = seq_q.pop_front(); apply(s); @(posedge clka); #1;
            got = snap(); exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL gravity_pause step %0d: got %h expected %h", k, got, exp);
            end
            k++;
        end
    endtask

    task automatic test_clear_levels();
        logic [EXP_W-1:0] got, exp;
        step_t s;
        int k;
        add(C_LDONE, 20'h0000F, S_CLEAR, 20'h0000F, 0, 0);
        add(9'h0, 20'h00F00, S_CLEAR, 20'h0000F, 0, 0);
        add(C_CDONE, '0, S_GEN, '0, 4, 0);
        add(C_GEN, '0, S_MOVE, '0, 4, 0);
        add(C_TOUCH, '0, S_LAND, '0, 4, 0);
        add(C_LDONE, 20'h80301, S_CLEAR, 20'h80301, 4, 0);
        add(C_CDONE, '0, S_GEN, '0, 8, 0);
        add(C_GEN, '0, S_MOVE, '0, 8, 0);
        add(C_TOUCH, '0, S_LAND, '0, 8, 0);
        add(C_LDONE, 20'hF0000, S_CLEAR, 20'hF0000, 8, 0);
        add(C_CDONE, '0, S_GEN, '0, 12, 1);
        add(C_GEN, '0, S_MOVE, '0, 12, 1);
        add(C_TOUCH, '0, S_LAND, '0, 12, 1);
        add(C_LDONE, 20'h00000, S_GEN, '0, 12, 1);
        add(C_GEN, '0, S_MOVE, '0, 12, 1);
        for (int i = 0; i < 16; i++) add(9'h0, '0, S_MOVE, '0, 12, 1);
        add(C_TOUCH, '0, S_LAND, '0, 12, 1);
        add(C_LDONE, 20'h000FF, S_CLEAR, 20'h000FF, 12, 1);
        add(C_CDONE, '0, S_GEN, '0, 20, 2);
        add(C_GEN, '0, S_MOVE, '0, 20, 2);
        for (int i = 0; i < 6; i++) add(9'h0, '0, S_MOVE, '0, 20, 2);
        k = 0;
        while (seq_q.size() > 0) begin
            s = seq_q.pop_front(); apply(s); @(posedge clka); #1;
            got = snap(); exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL clear_levels step %0d: got %h expected %h", k, got, exp);
            end
            k++;
        end
    endtask

    task automatic test_gameover();
        logic [EXP_W-1:0] got, exp;
        step_t s;
        int k;
        add(C_TOUCH, '0, S_LAND, '0, 20, 2);
        add(C_LDONE | C_LERR, 20'h000FF, S_OVER, '0, 20, 2);
        add(C_START | C_GEN | C_CDONE, '0, S_OVER, '0, 20, 2);
        add(C_RESTART, '0, S_NB, '0, 0, 0);
        add(C_START, '0, S_GEN, '0, 0, 0);
        add(C_GEN | C_SPAWN, '0, S_OVER, '0, 0, 0);
        add(9'h0, '0, S_OVER, '0, 0, 0);
        add(C_RESTART | C_START, '0, S_NB, '0, 0, 0);
        add(C_RESTART | C_START, '0, S_NB, '0, 0, 0);
        k = 0;
        while (seq_q.size() > 0) begin
            s = seq_q.pop_front(); apply(s); @(posedge clka); #1;
            got = snap(); exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL gameover step %0d: got %h expected %h", k, got, exp);
            end
            k++;
        end
    endtask

    task automatic test_restart();
        logic [EXP_W-1:0] got, exp;
        step_t s;
        int k;
        add(C_START, '0, S_GEN, '0, 0, 0);
        add(C_GEN, '0, S_MOVE, '0, 0, 0);
        for (int i = 0; i < 5; i++) add(9'h0, '0, S_MOVE, '0, 0, 0);
        add(C_RESTART | C_TOUCH, '0, S_NB, '0, 0, 0);
        add(C_START, '0, S_GEN, '0, 0, 0);
        add(C_GEN, '0, S_MOVE, '0, 0, 0);
        for (int i = 0; i < 10; i++) add(9'h0, '0, S_MOVE, '0, 0, 0);
        add(C_TOUCH, '0, S_LAND, '0, 0, 0);
        add(C_LDONE, 20'h00003, S_CLEAR, 20'h00003, 0, 0);
        add(C_RESTART | C_CDONE, '0, S_NB, '0, 0, 0);
        k = 0;
        while (seq_q.size() > 0) begin
            s = seq_q.pop_front(); apply(s); @(posedge clka); #1;
            got = snap(); exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL restart step %0d: got %h expected %h", k, got, exp);
            end
            k++;
        end
    endtask

    task automatic test_async_reset();
        logic [EXP_W-1:0] got, exp;
        step_t s;
        int k;
        add(C_START, '0, S_GEN, '0, 0, 0);
        add(C_GEN, '0, S_MOVE, '0, 0, 0);
        add(C_TOUCH, '0, S_LAND, '0, 0, 0);
        add(C_LDONE, 20'h00030, S_CLEAR, 20'h00030, 0, 0);
        add(C_CDONE, '0, S_GEN, '0, 2, 0);
        add(C_GEN, '0, S_MOVE, '0, 2, 0);
        add(C_TOUCH, '0, S_LAND, '0, 2, 0);
        add(C_LDONE, 20'h00007, S_CLEAR, 20'h00007, 2, 0);
        k = 0;
        while (seq_q.size() > 0) begin
            s = seq_q.pop_front(); apply(s); @(posedge clka); #1;
            got = snap(); exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL async_setup step %0d: got %h expected %h", k, got, exp);
            end
            k++;
        end
        // Reset lands mid-cycle, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        m_prev = S_NB;
        tcount = 0;
        exp_q.push_back(pack(S_NB, 0, 0, 0, 0, 0, '0, '0, '0));
        got = snap(); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", got, exp);
        end
        idle_inputs();
        clear_done = 1'b1;
        @(posedge clka); #1;
        rst_n = 1'b1;
        add(9'h0, '0, S_NB, '0, 0, 0);
        add(C_START, '0, S_GEN, '0, 0, 0);
        add(C_GEN, '0, S_MOVE, '0, 0, 0);
        k = 0;
        while (seq_q.size() > 0) begin
            s = seq_q.pop_front(); apply(s); @(posedge clka); #1;
            got = snap(); exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL async_recover step %0d: got %h expected %h", k, got, exp);
            end
            k++;
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_start_move();
        test_gravity_pause();
        test_clear_levels();
        test_gameover();
        test_restart();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
